vector_op_arbiter: RTL and testbench

Front-end scheduler for the vector coprocessor. Two scalar requesters each push vector ops (op word, LMUL, SEW) into a private FIFO. The block round-robin arbitrates between the FIFO heads and drives the coprocessor's operation interface one op at a time. It holds each op stable until the coprocessor signals completion, then returns a per-requester done pulse.

---
 rtl/vector_op_arbiter.sv | 151 +++++++++++++++
 tb/tb_vector_op_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_op_arbiter.sv
// Two per-requester op FIFOs feeding one coprocessor op interface. Round-robin grant,
// one op in flight, op held stable until the valid/ready handshake.
module vector_op_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        vsi_clk,
  input  logic        vsi_rst_n,
  input  logic [31:0] req0_op,
  input  logic        req0_lmul,
  input  logic        req0_sew,
  input  logic        req0_valid,
  output logic        req0_ready,
  output logic        req0_done,
  input  logic [31:0] req1_op,
  input  logic        req1_lmul,
  input  logic        req1_sew,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] cop_op,
  output logic        cop_lmul,
  output logic        cop_sew,
  output logic        cop_valid,
  input  logic        cop_ready,
  input  logic        cop_idle,
  output logic        grant_id,
  output logic        arb_idle
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic {ARB_IDLE, ARB_BUSY} state_e;
  state_e state_q, state_d;

  logic [33:0] wdata [2];
  logic [33:0] head  [2];
  logic [1:0]  valid_in, push, pop, nonempty, ready;

  logic [31:0] cop_op_q, cop_op_d;
  logic        cop_lmul_q, cop_lmul_d;
  logic        cop_sew_q, cop_sew_d;
  logic        cop_valid_q, cop_valid_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        complete;
  logic        win;

  assign wdata[0] = {req0_op, req0_lmul, req0_sew};
  assign wdata[1] = {req1_op, req1_lmul, req1_sew};
  assign valid_in = {req1_valid, req0_valid};
  assign push     = valid_in & ready;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [33:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;

    assign ready[g]    = (cnt_q != FULL);
    assign nonempty[g] = (cnt_q != '0);
    assign head[g]     = mem_q[rptr_q];

    // Storage carries no reset; emptiness is defined by the count alone.
    always_ff @(posedge vsi_clk) begin
      if (push[g]) mem_q[wptr_q] <= wdata[g];
    end

    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
      if (!vsi_rst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[g]) wptr_q <= wptr_q + 1'b1;
        if (pop[g])  rptr_q <= rptr_q + 1'b1;
        case ({push[g], pop[g]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign complete = (state_q == ARB_BUSY) && cop_valid_q && cop_ready;

  always_comb begin
    state_d     = state_q;
    cop_op_d    = cop_op_q;
    cop_lmul_d  = cop_lmul_q;
    cop_sew_d   = cop_sew_q;
    cop_valid_d = cop_valid_q;
    grant_d     = grant_q;
    last_d      = last_q;
    win         = 1'b0;
    pop         = '0;
    case (state_q)
      ARB_IDLE: begin
        if (cop_idle && (nonempty != 2'b00)) begin
          // Tie goes to whoever did not win last; otherwise the only non-empty side.
          win = (&nonempty) ? ~last_q : ~nonempty[0];
          {cop_op_d, cop_lmul_d, cop_sew_d} = head[win];
          cop_valid_d = 1'b1;
          grant_d     = win;
          last_d      = win;
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (complete) begin
          pop[grant_q] = 1'b1;
          cop_valid_d  = 1'b0;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      state_q     <= ARB_IDLE;
      cop_op_q    <= '0;
      cop_lmul_q  <= 1'b0;
      cop_sew_q   <= 1'b0;
      cop_valid_q <= 1'b0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cop_op_q    <= cop_op_d;
      cop_lmul_q  <= cop_lmul_d;
      cop_sew_q   <= cop_sew_d;
      cop_valid_q <= cop_valid_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign req0_done  = complete & ~grant_q;
  assign req1_done  = complete & grant_q;
  assign cop_op     = cop_op_q;
  assign cop_lmul   = cop_lmul_q;
  assign cop_sew    = cop_sew_q;
  assign cop_valid  = cop_valid_q;
  assign grant_id   = grant_q;
  assign arb_idle   = (nonempty == 2'b00) && !cop_valid_q;

endmodule

// File: tb/tb_vector_op_arbiter.sv
// Bench for vector_op_arbiter: queue-based transaction model checked every cycle,
// directed scenarios followed by a randomized run.
module tb_vector_op_arbiter;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] in0_op = '0, in1_op = '0;
  logic        in0_lmul = 1'b0, in0_sew = 1'b0, in0_valid = 1'b0;
  logic        in1_lmul = 1'b0, in1_sew = 1'b0, in1_valid = 1'b0;
  logic        cop_ready_r = 1'b0, cop_idle_r = 1'b1;

  logic        req0_ready, req0_done, req1_ready, req1_done;
  logic [31:0] cop_op;
  logic        cop_lmul, cop_sew, cop_valid, grant_id, arb_idle;

  vector_op_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .vsi_clk(clk), .vsi_rst_n(rst_n),
    .req0_op(in0_op), .req0_lmul(in0_lmul), .req0_sew(in0_sew), .req0_valid(in0_valid),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_op(in1_op), .req1_lmul(in1_lmul), .req1_sew(in1_sew), .req1_valid(in1_valid),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .cop_op(cop_op), .cop_lmul(cop_lmul), .cop_sew(cop_sew), .cop_valid(cop_valid),
    .cop_ready(cop_ready_r), .cop_idle(cop_idle_r),
    .grant_id(grant_id), .arb_idle(arb_idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-requester queues plus the single in-flight op.
  logic [33:0] mq0[$], mq1[$];
  logic        m_valid, m_gid, m_last, m_lmul, m_sew;
  logic [31:0] m_op;
  int unsigned m_age;
  bit          hold = 1'b0;
  bit          acc1;
  int unsigned done0_cnt, done1_cnt, gcnt;
  logic [15:0] gseq;
  logic        prev_cv = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_valid = 1'b0; m_gid = 1'b0; m_last = 1'b1;
    m_op = '0; m_lmul = 1'b0; m_sew = 1'b0; m_age = 0;
  endtask

  task automatic check_reset(input string tag);
    check_eq(tag, 64'({cop_valid, cop_op, cop_lmul, cop_sew, grant_id,
                       req0_ready, req1_ready, req0_done, req1_done, arb_idle}),
             64'({1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}));
  endtask

  task automatic set_push(input int unsigned n, input logic [31:0] op, input logic l, input logic s);
    if (n == 0) begin
      in0_op = op; in0_lmul = l; in0_sew = s; in0_valid = 1'b1;
    end else begin
      in1_op = op; in1_lmul = l; in1_sew = s; in1_valid = 1'b1;
    end
  endtask

  task automatic clear_push();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic run_cycle();
    logic p0, p1, w, r0, r1;
    logic [33:0] e;
    cop_ready_r = m_valid && !hold && (m_age >= (m_lmul ? 32'd4 : 32'd3));
    #1;
    r0 = (mq0.size() != DEPTH);
    r1 = (mq1.size() != DEPTH);
    check_eq("cop_op", 64'(cop_op), 64'(m_op));
    check_eq("ctl", 64'({req0_ready, req1_ready, req0_done, req1_done,
                         cop_valid, cop_lmul, cop_sew, grant_id, arb_idle}),
             64'({r0, r1, m_valid && cop_ready_r && !m_gid, m_valid && cop_ready_r && m_gid,
                  m_valid, m_lmul, m_sew, m_gid,
                  (mq0.size() == 0) && (mq1.size() == 0) && !m_valid}));
    if (req0_done) done0_cnt++;
    if (req1_done) done1_cnt++;
    if (cop_valid && !prev_cv) begin
      if (gcnt < 16) gseq[gcnt[3:0]] = grant_id;
      gcnt++;
    end
    prev_cv = cop_valid;

    p0 = in0_valid && r0;
    p1 = in1_valid && r1;
    acc1 = p1;
    if (m_valid && cop_ready_r) begin
      if (m_gid) void'(mq1.pop_front());
      else       void'(mq0.pop_front());
      m_valid = 1'b0;
    end else if (m_valid) begin
      m_age++;
    end else if (cop_idle_r && (mq0.size() + mq1.size() > 0)) begin
      w = (mq0.size() > 0 && mq1.size() > 0) ? ~m_last : (mq0.size() == 0);
      e = w ? mq1[0] : mq0[0];
      {m_op, m_lmul, m_sew} = e;
      m_valid = 1'b1; m_gid = w; m_last = w; m_age = 0;
    end
    if (p0) mq0.push_back({in0_op, in0_lmul, in0_sew});
    if (p1) mq1.push_back({in1_op, in1_lmul, in1_sew});
    @(negedge clk);
  endtask

  initial begin
    bit rose;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: three ops each, pushed together.
    gcnt = 0; gseq = '0; done0_cnt = 0; done1_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      set_push(0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_push(1, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_cycle();
    end
    clear_push();
    repeat (45) run_cycle();
    check_eq("fair_count", 64'(gcnt), 64'd6);
    check_eq("fair_order", 64'(gseq[5:0]), 64'(6'b101010));
    check_eq("fair_done", 64'({done0_cnt[7:0], done1_cnt[7:0]}), 64'({8'd3, 8'd3}));

    // Single op latency.
    done0_cnt = 0;
    set_push(0, 32'h2E00_0057, 1'b0, 1'b1);
    run_cycle();
    clear_push();
    check_eq("single_pre", 64'(cop_valid), 64'd0);
    run_cycle();
    check_eq("single_issue", 64'({cop_valid, grant_id, cop_op}), 64'({1'b1, 1'b0, 32'h2E00_0057}));
    repeat (6) run_cycle();
    check_eq("single_done", 64'(done0_cnt), 64'd1);
    check_eq("single_idle", 64'(arb_idle), 64'd1);

    // Full FIFO on req1 with completion held off.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_push(1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      run_cycle();
    end
    check_eq("full_ready", 64'(req1_ready), 64'd0);
    set_push(1, 32'h1000_0004, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check_eq("full_hold", 64'(req1_ready), 64'd0);
    end
    hold = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 15; i++) begin
      run_cycle();
      if (acc1) in1_valid = 1'b0;
      if (req1_ready) rose = 1'b1;
    end
    check_eq("full_rise", 64'(rose), 64'd1);
    clear_push();
    repeat (40) run_cycle();

    // Stability of a held LMUL=1 op, with a req1 push landing mid-flight.
    set_push(0, 32'hB600_0057, 1'b1, 1'b0);
    run_cycle();
    clear_push();
    for (int i = 0; i < 6; i++) begin
      if (i == 1) set_push(1, 32'h0200_0057, 1'b0, 1'b1);
      if (i == 2) clear_push();
      run_cycle();
      if (cop_valid) check_eq("stable", 64'({cop_op, cop_lmul, cop_sew}), 64'({32'hB600_0057, 1'b1, 1'b0}));
    end
    repeat (12) run_cycle();

    // cop_idle gating.
    cop_idle_r = 1'b0;
    set_push(0, 32'h5E00_0057, 1'b0, 1'b0);
    run_cycle();
    clear_push();
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check_eq("gate_low", 64'(cop_valid), 64'd0);
    end
    cop_idle_r = 1'b1;
    run_cycle();
    check_eq("gate_grant", 64'(cop_valid), 64'd1);
    repeat (10) run_cycle();

    // Reset while busy with two entries queued.
    hold = 1'b1;
    set_push(0, 32'hAAAA_0057, 1'b0, 1'b0);
    run_cycle();
    set_push(0, 32'hBBBB_0057, 1'b1, 1'b1);
    run_cycle();
    clear_push();
    repeat (3) run_cycle();
    check_eq("mid_busy", 64'(cop_valid), 64'd1);
    cop_ready_r = 1'b1;
    rst_n = 1'b0;
    #1 check_reset("mid_rst");
    model_reset();
    @(posedge clk);
    #1 check_reset("mid_rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    repeat (3) run_cycle();
    check_eq("mid_after", 64'({arb_idle, req0_ready, req1_ready}), 64'(3'b111));

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      in0_valid = ($urandom_range(0, 9) < 4);
      in1_valid = ($urandom_range(0, 9) < 4);
      in0_op = $urandom; in0_lmul = 1'($urandom_range(0, 1)); in0_sew = 1'($urandom_range(0, 1));
      in1_op = $urandom; in1_lmul = 1'($urandom_range(0, 1)); in1_sew = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0);
      cop_idle_r = ($urandom_range(0, 6) != 0);
      run_cycle();
    end
    clear_push();
    hold = 1'b0;
    cop_idle_r = 1'b1;
    repeat (60) run_cycle();
    check_eq("final_idle", 64'(arb_idle), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
